pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_data_reg.sv | 17 +
 rtl/pipe_skid_reg.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffer pipeline register: state encoding and
// occupancy width, plus the state-to-occupancy decode.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Enable-loaded payload register with asynchronous active-low clear to zero.
module pipe_data_reg #(
  parameter int WIDTH = 222
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage: two-entry skid buffer (SKID_EN=1) or a single
// enable register with combinational ready (SKID_EN=0).
//   state | meaning
//   EMPTY | nothing held
//   BUSY  | main register holds the head entry
//   FULL  | main holds head, skid holds the next entry (SKID_EN=1 only)
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 222,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  state_t           state_q, state_d;
  logic             main_en, skid_en;
  logic             accept, pop;
  logic [WIDTH-1:0] main_d, skid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign out_valid = (state_q != EMPTY);
  assign occupancy = occ_of(state_q);

  // Skid mode decodes ready from the register alone to break the out_ready path.
  assign in_ready = SKID_EN ? (state_q != FULL) : (out_ready | (state_q == EMPTY));

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign main_d = (state_q == FULL) ? skid_q : in_data;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && pop) begin
          main_en = 1'b1;
        end else if (accept && SKID_EN) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush clears validity only; the data registers keep their contents.
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (out_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
      );
    end else begin : g_no_skid
      logic unused_skid_en;
      assign unused_skid_en = skid_en;
      assign skid_q         = '0;
    end
  endgenerate

endmodule
